seq_detect_fsm: RTL and testbench

- Parametrised serial pattern-detector FSM. It samples a 1-bit input stream and pulses `match` when the last PAT_W sampled bits equal PATTERN.
- Successor to the fixed 4-state single-always FSMs: it adds a configurable pattern and width, overlap mode, enable/clear, and a saturating match counter.
- Sits on serial control/flag lines in front of higher-level sequencers.

---
 rtl/seq_detect_fsm_if.sv | 18 +
 rtl/seq_detect_fsm.sv | 101 ++++++++++
 tb/tb_seq_detect_fsm.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/seq_detect_fsm_if.sv
// Serial pattern-detector port bundle: sample controls and data in, detector status out.
interface seq_detect_fsm_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  localparam int ST_W = $clog2(PAT_W + 1);

  logic             en;
  logic             clr;
  logic             din;
  logic             match;
  logic [ST_W-1:0]  state;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (output en, clr, din, input match, state, match_cnt, cnt_sat);
  modport slave  (input en, clr, din, output match, state, match_cnt, cnt_sat);
endinterface

// File: rtl/seq_detect_fsm.sv
// Parametrised serial pattern detector: a KMP automaton built at elaboration,
// with overlap control, enable/clear and a saturating match counter.
module seq_detect_fsm #(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input logic             clk,
  input logic             reset,
  seq_detect_fsm_if.slave bus
);
  localparam int ST_W  = $clog2(PAT_W + 1);
  localparam int TBL_W = 2 * PAT_W * ST_W;

  // Longest proper prefix of PATTERN that is a suffix of S, where S is the
  // first k pattern bits followed by b. Bit j of a prefix is PATTERN[PAT_W-1-j].
  function automatic int longest_border(input int k, input logic b);
    int   best;
    int   si;
    logic ok;
    logic sb;
    best = 0;
    for (int l = 1; l < PAT_W; l++) begin
      if (l <= k + 1) begin
        ok = 1'b1;
        for (int j = 0; j < PAT_W; j++) begin
          if (j < l) begin
            si = k + 1 - l + j;
            sb = (si < k) ? PATTERN[PAT_W-1-si] : b;
            if (sb != PATTERN[PAT_W-1-j]) ok = 1'b0;
          end
        end
        if (ok) best = l;
      end
    end
    return best;
  endfunction

  function automatic logic [TBL_W-1:0] build_tbl();
    logic [TBL_W-1:0] t;
    logic             b;
    int               nxt;
    t = '0;
    for (int k = 0; k < PAT_W; k++) begin
      for (int bb = 0; bb < 2; bb++) begin
        b = (bb != 0);
        if ((k == PAT_W - 1) && (b == PATTERN[0]))
          nxt = OVERLAP ? longest_border(k, b) : 0;
        else
          nxt = longest_border(k, b);
        t[(2*k + bb)*ST_W +: ST_W] = ST_W'(nxt);
      end
    end
    return t;
  endfunction

  localparam logic [TBL_W-1:0] NEXT_TBL = build_tbl();

  logic [ST_W-1:0]  state_p0, state_d;
  logic             match_p0, match_d;
  logic [CNT_W-1:0] cnt_p0, cnt_d;
  int               tbl_base;

  always_comb begin
    state_d  = state_p0;
    match_d  = 1'b0;
    cnt_d    = cnt_p0;
    tbl_base = (int'(state_p0) * 2 + int'(bus.din)) * ST_W;
    if (bus.clr) begin
      state_d = '0;
      cnt_d   = '0;
    end else if (state_p0 >= ST_W'(PAT_W)) begin
      state_d = '0;
    end else if (bus.en) begin
      state_d = NEXT_TBL[tbl_base +: ST_W];
      if ((state_p0 == ST_W'(PAT_W - 1)) && (bus.din == PATTERN[0])) begin
        match_d = 1'b1;
        if (!(&cnt_p0)) cnt_d = cnt_p0 + CNT_W'(1);
      end
    end
  end

  // Stage p0: registered detector state, match pulse and counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0 <= '0;
      match_p0 <= 1'b0;
      cnt_p0   <= '0;
    end else begin
      state_p0 <= state_d;
      match_p0 <= match_d;
      cnt_p0   <= cnt_d;
    end
  end

  assign bus.state     = state_p0;
  assign bus.match     = match_p0;
  assign bus.match_cnt = cnt_p0;
  assign bus.cnt_sat   = &cnt_p0;
endmodule

// File: tb/tb_seq_detect_fsm.sv
// Directed bench for seq_detect_fsm: overlap, non-overlap and narrow-counter
// instances share one stimulus stream.
module tb_seq_detect_fsm;
  logic clk = 1'b0;
  logic reset;
  logic en, clr, din;
  int   total = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  seq_detect_fsm_if #(.PAT_W(4), .CNT_W(8)) ifa ();
  seq_detect_fsm_if #(.PAT_W(4), .CNT_W(8)) ifb ();
  seq_detect_fsm_if #(.PAT_W(4), .CNT_W(2)) ifc ();

  assign ifa.en = en;  assign ifa.clr = clr;  assign ifa.din = din;
  assign ifb.en = en;  assign ifb.clr = clr;  assign ifb.din = din;
  assign ifc.en = en;  assign ifc.clr = clr;  assign ifc.din = din;

  seq_detect_fsm #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8))
    dut_ov (.clk(clk), .reset(reset), .bus(ifa));
  seq_detect_fsm #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8))
    dut_no (.clk(clk), .reset(reset), .bus(ifb));
  seq_detect_fsm #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2))
    dut_sat (.clk(clk), .reset(reset), .bus(ifc));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input logic c, input logic b);
    @(negedge clk);
    en = e; clr = c; din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_clear(input string tag);
    chk({tag, "_st_ov"},  32'(ifa.state), 0);
    chk({tag, "_st_no"},  32'(ifb.state), 0);
    chk({tag, "_m_ov"},   32'(ifa.match), 0);
    chk({tag, "_cnt_ov"}, 32'(ifa.match_cnt), 0);
    chk({tag, "_cnt_no"}, 32'(ifb.match_cnt), 0);
    chk({tag, "_cnt_sat"}, 32'(ifc.match_cnt), 0);
  endtask

  int s1_din[7]   = '{1, 0, 1, 1, 0, 1, 1};
  int s1_stov[7]  = '{1, 2, 3, 1, 2, 3, 1};
  int s1_stno[7]  = '{1, 2, 3, 0, 0, 1, 1};
  int s1_mov[7]   = '{0, 0, 0, 1, 0, 0, 1};
  int s1_mno[7]   = '{0, 0, 0, 1, 0, 0, 0};
  int s2_din[6]   = '{1, 0, 1, 0, 1, 1};
  int s2_stov[6]  = '{1, 2, 3, 2, 3, 1};
  int s2_stno[6]  = '{1, 2, 3, 2, 3, 0};
  int s2_m[6]     = '{0, 0, 0, 0, 0, 1};
  int sat_cnt[5]  = '{1, 2, 3, 3, 3};
  int sat_flag[5] = '{0, 0, 1, 1, 1};

  initial begin
    reset = 1'b1; en = 1'b0; clr = 1'b0; din = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_clear("reset");
    chk("reset_cntsat", 32'(ifc.cnt_sat), 0);
    @(negedge clk);
    reset = 1'b0;

    // Overlap vs. non-overlap on 1011011
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, s1_din[i][0]);
      chk($sformatf("s1_st_ov%0d", i), 32'(ifa.state), s1_stov[i]);
      chk($sformatf("s1_st_no%0d", i), 32'(ifb.state), s1_stno[i]);
      chk($sformatf("s1_m_ov%0d", i),  32'(ifa.match), s1_mov[i]);
      chk($sformatf("s1_m_no%0d", i),  32'(ifb.match), s1_mno[i]);
    end
    chk("s1_cnt_ov", 32'(ifa.match_cnt), 2);
    chk("s1_cnt_no", 32'(ifb.match_cnt), 1);

    step(1'b0, 1'b1, 1'b1);
    chk_all_clear("clr1");

    // KMP failure transition on 101011
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, s2_din[i][0]);
      chk($sformatf("s2_st_ov%0d", i), 32'(ifa.state), s2_stov[i]);
      chk($sformatf("s2_st_no%0d", i), 32'(ifb.state), s2_stno[i]);
      chk($sformatf("s2_m_no%0d", i),  32'(ifb.match), s2_m[i]);
    end
    chk("s2_cnt_ov", 32'(ifa.match_cnt), 1);

    step(1'b0, 1'b1, 1'b0);
    chk_all_clear("clr2");

    // Enable gap between bits 2 and 3, then a stalled final bit
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1);
      chk($sformatf("gap_st%0d", i), 32'(ifa.state), 2);
      chk($sformatf("gap_m%0d", i),  32'(ifa.match), 0);
    end
    step(1'b1, 1'b0, 1'b1);
    chk("gap_st3", 32'(ifa.state), 3);
    step(1'b0, 1'b0, 1'b1);
    chk("stall_st", 32'(ifa.state), 3);
    chk("stall_m",  32'(ifa.match), 0);
    chk("stall_cnt", 32'(ifa.match_cnt), 0);
    step(1'b1, 1'b0, 1'b1);
    chk("gap_m_ov",  32'(ifa.match), 1);
    chk("gap_st_ov", 32'(ifa.state), 1);
    chk("gap_cnt",   32'(ifa.match_cnt), 1);

    step(1'b0, 1'b1, 1'b0);
    chk_all_clear("clr3");

    // Clear on the completing bit wins
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk_all_clear("clrfin");
    chk("clrfin_m_no", 32'(ifb.match), 0);

    // Five back-to-back patterns into the 2-bit counter
    for (int p = 0; p < 5; p++) begin
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      chk($sformatf("sat_mid_m%0d", p), 32'(ifc.match), 0);
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      chk($sformatf("sat_m%0d", p),    32'(ifc.match), 1);
      chk($sformatf("sat_cnt%0d", p),  32'(ifc.match_cnt), sat_cnt[p]);
      chk($sformatf("sat_flag%0d", p), 32'(ifc.cnt_sat), sat_flag[p]);
    end
    chk("sat_cnt_ov", 32'(ifa.match_cnt), 5);
    chk("sat_cnt_no", 32'(ifb.match_cnt), 5);
    chk("sat_flag_ov", 32'(ifa.cnt_sat), 0);

    // Asynchronous reset between edges, mid-pattern
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("pre_rst_st", 32'(ifa.state), 3);
    #2;
    reset = 1'b1;
    #1;
    chk_all_clear("arst");
    chk("arst_cntsat", 32'(ifc.cnt_sat), 0);
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b1);
    chk("post_rst_st", 32'(ifa.state), 1);
    chk("post_rst_m",  32'(ifa.match), 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
